// File: rtl/sim_run_controller.sv
// Run controller: sequences core reset, counts RUN cycles, flags per-core halt by PC stall,
// and ends the run on all-halted or cycle limit. Optional PC signature under SIM_SIGNATURE_EN.
module sim_run_controller #(
  parameter int unsigned NUM_CORES    = 1,
  parameter int unsigned PC_W         = 16,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned STALL_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CORES*PC_W-1:0] pc_in,
  output logic                      core_reset,
  output logic                      running,
  output logic [NUM_CORES-1:0]      core_halted,
  output logic [CNT_W-1:0]          cycle_count,
  output logic                      done,
  output logic                      timeout,
  output logic [31:0]               signature
);

  localparam int unsigned SC_W = $clog2(STALL_CYCLES + 1);
  localparam int unsigned HC_W = $clog2(RESET_CYCLES + 1);

  // Parameter legality
  if (MAX_CYCLES == 0) begin : g_chk_max_zero
    $error("sim_run_controller: MAX_CYCLES must be >= 1");
  end
  if ((64'(MAX_CYCLES) >> CNT_W) != 64'd0) begin : g_chk_max_wide
    $error("sim_run_controller: MAX_CYCLES must be < 2**CNT_W");
  end
  if (RESET_CYCLES < 1) begin : g_chk_reset
    $error("sim_run_controller: RESET_CYCLES must be >= 1");
  end
  if (STALL_CYCLES < 2) begin : g_chk_stall
    $error("sim_run_controller: STALL_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t                          state, state_d;
  logic [HC_W-1:0]                 hold_cnt, hold_cnt_d;
  logic [NUM_CORES-1:0][PC_W-1:0]  prev_pc, prev_pc_d;
  logic [NUM_CORES-1:0][SC_W-1:0]  stall_cnt, stall_cnt_d;
  logic                            prev_valid, prev_valid_d;
  logic [NUM_CORES-1:0]            halted_d;
  logic [CNT_W-1:0]                count_d;
  logic                            done_d, timeout_d, core_reset_d, running_d;
  logic                            launch;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    hold_cnt_d   = hold_cnt;
    prev_pc_d    = prev_pc;
    stall_cnt_d  = stall_cnt;
    prev_valid_d = prev_valid;
    halted_d     = core_halted;
    count_d      = cycle_count;
    done_d       = done;
    timeout_d    = timeout;
    launch       = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        launch = start;
      end
      RESET_HOLD: begin
        hold_cnt_d = hold_cnt + HC_W'(1);
        if (hold_cnt == HC_W'(RESET_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        count_d      = cycle_count + CNT_W'(1);
        prev_valid_d = 1'b1;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
          prev_pc_d[i] = pc_in[i*PC_W +: PC_W];
          // No compare in the first RUN cycle: prev_pc is not yet meaningful
          if (prev_valid) begin
            if (pc_in[i*PC_W +: PC_W] == prev_pc[i]) begin
              if (stall_cnt[i] != SC_W'(STALL_CYCLES)) stall_cnt_d[i] = stall_cnt[i] + SC_W'(1);
            end else begin
              stall_cnt_d[i] = '0;
            end
          end
          if (stall_cnt_d[i] == SC_W'(STALL_CYCLES)) halted_d[i] = 1'b1;
        end
        // All-halted takes priority over the cycle limit
        if (&halted_d) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (count_d == CNT_W'(MAX_CYCLES)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d      = RESET_HOLD;
      hold_cnt_d   = '0;
      prev_valid_d = 1'b0;
      stall_cnt_d  = '0;
      halted_d     = '0;
      count_d      = '0;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
    end

    core_reset_d = (state_d != RUN);
    running_d    = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      prev_pc     <= '0;
      stall_cnt   <= '0;
      prev_valid  <= 1'b0;
      core_halted <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      core_reset  <= 1'b1;
      running     <= 1'b0;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_cnt_d;
      prev_pc     <= prev_pc_d;
      stall_cnt   <= stall_cnt_d;
      prev_valid  <= prev_valid_d;
      core_halted <= halted_d;
      cycle_count <= count_d;
      done        <= done_d;
      timeout     <= timeout_d;
      core_reset  <= core_reset_d;
      running     <= running_d;
    end
  end

`ifdef SIM_SIGNATURE_EN
  logic [31:0] sig_q, sig_d, pc_xor;

  // Rotate-left-and-fold of the XOR of all core PCs, once per RUN cycle
  always_comb begin
    pc_xor = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      pc_xor = pc_xor ^ 32'(pc_in[i*PC_W +: PC_W]);
    end
    sig_d = sig_q;
    if (launch) begin
      sig_d = '0;
    end else if (state == RUN) begin
      sig_d = {sig_q[30:0], sig_q[31]} ^ pc_xor;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  assign signature = 32'h0;
`endif

endmodule
